// File: rtl/jpeg_byte_stuffer.sv
// Serialises JPEG bitstream words into a byte stream with 0xFF00 stuffing,
// 1-padding of the final partial byte and an appended EOI marker.
module jpeg_byte_stuffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        last_valid,
  input  logic [4:0]  orc_in,
  output logic        word_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        eoi_done,
  output logic        busy,
  output logic        overflow,
  output logic        proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, STUFF, EOI_FF, EOI_D9} state_t;

  // Unused low bits of a partial word are forced to 1; bytes past the
  // valid count are never emitted, so padding the whole tail is harmless.
  function automatic logic [31:0] pad_tail(input logic [31:0] d, input logic [4:0] orc);
    return d | (32'hFFFF_FFFF >> orc);
  endfunction

  function automatic logic [2:0] byte_count(input logic last, input logic [4:0] orc);
    logic [5:0] s;
    s = {1'b0, orc} + 6'd7;
    return last ? s[5:3] : 3'd4;
  endfunction

  logic [37:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, accept;

  logic [37:0]   head;
  logic          head_last;
  logic [31:0]   head_pad;
  logic [2:0]    head_n;

  state_t        state;
  logic [31:0]   shreg;
  logic [2:0]    bytes_left;
  logic          last_r;
  logic          hs, adv, refill;

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign push   = word_valid | last_valid;
  assign accept = push & (!full | pop);

  assign head      = mem[rd_ptr];
  assign head_last = head[37];
  assign head_pad  = head_last ? pad_tail(head[31:0], head[36:32]) : head[31:0];
  assign head_n    = byte_count(head_last, head[36:32]);

  // adv: a non-0xFF data byte or a stuffed 0x00 was just accepted
  assign hs     = byte_valid & byte_ready;
  assign adv    = hs & (((state == SEND) & (byte_out != 8'hFF)) | (state == STUFF));
  assign refill = adv & (bytes_left == 3'd0) & !last_r;
  assign pop    = !empty & ((state == IDLE) | refill);

  assign word_ready = !full;
  assign busy       = !empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= {last_valid & ~word_valid,
                      (last_valid & ~word_valid) ? orc_in : 5'd0,
                      word_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !accept)          overflow  <= 1'b1;
      if (word_valid && last_valid) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      eoi_done   <= 1'b0;
    end else begin
      eoi_done <= 1'b0;
      if (adv) begin
        if (bytes_left != 3'd0) begin
          byte_out   <= shreg[31:24];
          shreg      <= shreg << 8;
          bytes_left <= bytes_left - 3'd1;
          state      <= SEND;
        end else if (last_r) begin
          byte_out <= 8'hFF;
          state    <= EOI_FF;
        end else if (!empty) begin
          // Back-to-back load from the FIFO head without a LOAD bubble
          last_r <= head_last;
          if (head_last && head_n == 3'd0) begin
            byte_out <= 8'hFF;
            state    <= EOI_FF;
          end else begin
            byte_out   <= head_pad[31:24];
            shreg      <= head_pad << 8;
            bytes_left <= head_n - 3'd1;
            state      <= SEND;
          end
        end else begin
          byte_valid <= 1'b0;
          state      <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!empty) begin
              shreg      <= head_pad;
              last_r     <= head_last;
              bytes_left <= head_n;
              state      <= LOAD;
            end
          end
          LOAD: begin
            byte_valid <= 1'b1;
            if (bytes_left == 3'd0) begin
              byte_out <= 8'hFF;
              state    <= EOI_FF;
            end else begin
              byte_out   <= shreg[31:24];
              shreg      <= shreg << 8;
              bytes_left <= bytes_left - 3'd1;
              state      <= SEND;
            end
          end
          SEND: begin
            if (hs) begin
              byte_out <= 8'h00;
              state    <= STUFF;
            end
          end
          STUFF: begin
            state <= STUFF;
          end
          EOI_FF: begin
            if (hs) begin
              byte_out <= 8'hD9;
              state    <= EOI_D9;
            end
          end
          EOI_D9: begin
            if (hs) begin
              byte_valid <= 1'b0;
              eoi_done   <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
